// File: rtl/fifo_counted.sv
// fifo_counted: synchronous single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, selectable read mode and sticky error flags.
//
// Any DEPTH >= 2 is supported and every entry is usable; pointers wrap explicitly
// at DEPTH-1, so a non-power-of-two depth behaves exactly like a power-of-two one.
//
// Ports
//   CLOCK_50      in   system clock, rising edge
//   RST_N         in   synchronous active-low reset
//   data_in       in   write data
//   write         in   write request
//   read          in   read/pop request
//   clear_errors  in   clears overflow and underflow (a new error in the same cycle wins)
//   data_out      out  read data (registered, or first-word-fall-through if SHOW_AHEAD)
//   empty         out  count == 0
//   full          out  count == DEPTH
//   almost_empty  out  count <= ALMOST_EMPTY_LEVEL
//   almost_full   out  count >= ALMOST_FULL_LEVEL
//   count         out  current occupancy, 0..DEPTH
//   overflow      out  sticky: a write was rejected
//   underflow     out  sticky: a read was rejected
module fifo_counted #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned DEPTH              = 16,
  parameter int          ALMOST_FULL_LEVEL  = int'(DEPTH) - 4,
  parameter int          ALMOST_EMPTY_LEVEL = 4,
  parameter bit          SHOW_AHEAD         = 1'b0
) (
  input  logic                         CLOCK_50,
  input  logic                         RST_N,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         write,
  input  logic                         read,
  input  logic                         clear_errors,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic empty_int;
  logic full_int;
  logic rd_acc;
  logic wr_acc;

  // Explicit wrap keeps the pointer inside 0..DEPTH-1 for any depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Status is decoded from the count register only.
  always_comb begin
    empty_int    = (count_q == '0);
    full_int     = (count_q == CNT_W'(DEPTH));
    almost_full  = (int'(count_q) >= ALMOST_FULL_LEVEL);
    almost_empty = (int'(count_q) <= ALMOST_EMPTY_LEVEL);
  end

  // A write while full is only accepted when a read frees a slot on the same edge.
  // A read on empty is never accepted, even alongside a write.
  always_comb begin
    rd_acc = read && !empty_int;
    wr_acc = write && (!full_int || rd_acc);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q && !clear_errors;
    underflow_d = underflow_q && !clear_errors;

    if (wr_acc) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (rd_acc) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Set has priority over clear_errors.
    if (write && !wr_acc) begin
      overflow_d = 1'b1;
    end
    if (read && !rd_acc) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; a write coinciding with reset is dropped.
  always_ff @(posedge CLOCK_50) begin
    if (RST_N && wr_acc) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  generate
    if (SHOW_AHEAD) begin : g_fwft
      // Head entry is visible as soon as it is stored; zero while empty.
      assign data_out = empty_int ? '0 : mem[rd_ptr_q];
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] data_out_q;

      always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
          data_out_q <= '0;
        end else if (rd_acc) begin
          data_out_q <= mem[rd_ptr_q];
        end
      end

      assign data_out = data_out_q;
    end
  endgenerate

  assign empty     = empty_int;
  assign full      = full_int;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  ptr_in_range_a : assert property (@(posedge CLOCK_50) disable iff (!RST_N)
    (32'(wr_ptr_q) < DEPTH) && (32'(rd_ptr_q) < DEPTH));

  count_in_range_a : assert property (@(posedge CLOCK_50) disable iff (!RST_N)
    32'(count_q) <= DEPTH);

endmodule

// File: tb/tb_fifo_counted.sv
// Bench for fifo_counted: three instances (16-deep registered, 10-deep registered with
// custom thresholds, 5-deep show-ahead) share one stimulus stream. Each has a queue-based
// reference model; directed vectors and hand-written sequences add constant expectations.
module tb_fifo_counted;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic        wr;
  logic        rd;
  logic        clr;

  logic [31:0] dout0, dout1, dout2;
  logic        emp0, emp1, emp2;
  logic        full0, full1, full2;
  logic        ae0, ae1, ae2;
  logic        af0, af1, af2;
  logic [4:0]  cnt0;
  logic [3:0]  cnt1;
  logic [2:0]  cnt2;
  logic        ov0, ov1, ov2;
  logic        un0, un1, un2;

  localparam int DEP [3] = '{16, 10, 5};
  localparam int AFL [3] = '{12, 8, 1};
  localparam int AEL [3] = '{4, 2, 4};
  localparam int SA  [3] = '{0, 0, 1};

  fifo_counted #(.DATA_WIDTH(32), .DEPTH(16), .SHOW_AHEAD(1'b0)) u_a (
    .CLOCK_50(clk), .RST_N(rst_n), .data_in(din), .write(wr), .read(rd),
    .clear_errors(clr), .data_out(dout0), .empty(emp0), .full(full0),
    .almost_empty(ae0), .almost_full(af0), .count(cnt0), .overflow(ov0), .underflow(un0)
  );

  fifo_counted #(.DATA_WIDTH(32), .DEPTH(10), .ALMOST_FULL_LEVEL(8),
                 .ALMOST_EMPTY_LEVEL(2), .SHOW_AHEAD(1'b0)) u_b (
    .CLOCK_50(clk), .RST_N(rst_n), .data_in(din), .write(wr), .read(rd),
    .clear_errors(clr), .data_out(dout1), .empty(emp1), .full(full1),
    .almost_empty(ae1), .almost_full(af1), .count(cnt1), .overflow(ov1), .underflow(un1)
  );

  fifo_counted #(.DATA_WIDTH(32), .DEPTH(5), .SHOW_AHEAD(1'b1)) u_c (
    .CLOCK_50(clk), .RST_N(rst_n), .data_in(din), .write(wr), .read(rd),
    .clear_errors(clr), .data_out(dout2), .empty(emp2), .full(full2),
    .almost_empty(ae2), .almost_full(af2), .count(cnt2), .overflow(ov2), .underflow(un2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference models: contents as queues, plus sticky flags and last popped word.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic        ovm [3];
  logic        unm [3];
  logic [31:0] doutm [3];

  typedef struct {
    logic        w;
    logic        r;
    logic        c;
    logic        rs;
    logic [31:0] d;
    int          cnt;
    logic        ov;
    logic        un;
    logic [31:0] dout;
    logic        full;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic w, input logic r, input logic c, input logic rs,
                              input logic [31:0] d, input int cnt, input logic ov,
                              input logic un, input logic [31:0] dout, input logic full);
    vec_t v;
    v.w = w; v.r = r; v.c = c; v.rs = rs; v.d = d;
    v.cnt = cnt; v.ov = ov; v.un = un; v.dout = dout; v.full = full;
    vecs.push_back(v);
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [31:0] qhead(input int k);
    if (qsize(k) == 0) return 32'h0;
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Advances model k by one clock edge using the inputs applied for that edge.
  task automatic model_edge(input int k);
    logic [31:0] q[$];
    logic [31:0] head;
    bit          rok;
    bit          wok;
    case (k)
      0:       q = q0;
      1:       q = q1;
      default: q = q2;
    endcase
    if (!rst_n) begin
      q.delete();
      ovm[k]   = 1'b0;
      unm[k]   = 1'b0;
      doutm[k] = 32'h0;
    end else begin
      rok = rd && (q.size() > 0);
      wok = wr && ((q.size() < DEP[k]) || rok);
      if (rok) begin
        head = q.pop_front();
        if (SA[k] == 0) doutm[k] = head;
      end
      if (wok) q.push_back(din);
      ovm[k] = (ovm[k] && !clr) || (wr && !wok);
      unm[k] = (unm[k] && !clr) || (rd && !rok);
    end
    case (k)
      0:       q0 = q;
      1:       q1 = q;
      default: q2 = q;
    endcase
  endtask

  task automatic chk_model(input int k, input string tag, input logic [31:0] c,
                           input logic e, input logic f, input logic ae, input logic af,
                           input logic [31:0] d, input logic o, input logic u);
    int          n;
    logic [31:0] expd;
    n    = qsize(k);
    expd = (SA[k] != 0) ? qhead(k) : doutm[k];
    chk({tag, " count"}, c, 32'(n));
    chk1({tag, " empty"}, e, n == 0);
    chk1({tag, " full"}, f, n == DEP[k]);
    chk1({tag, " almost_empty"}, ae, n <= AEL[k]);
    chk1({tag, " almost_full"}, af, n >= AFL[k]);
    chk({tag, " data_out"}, d, expd);
    chk1({tag, " overflow"}, o, ovm[k]);
    chk1({tag, " underflow"}, u, unm[k]);
  endtask

  task automatic cycle(input logic w, input logic r, input logic c, input logic rs,
                       input logic [31:0] d);
    wr    = w;
    rd    = r;
    clr   = c;
    rst_n = rs;
    din   = d;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    chk_model(0, "A", 32'(cnt0), emp0, full0, ae0, af0, dout0, ov0, un0);
    chk_model(1, "B", 32'(cnt1), emp1, full1, ae1, af1, dout1, ov1, un1);
    chk_model(2, "C", 32'(cnt2), emp2, full2, ae2, af2, dout2, ov2, un2);
  endtask

  initial begin
    int writes;
    int iter;
    int n;
    logic w;
    logic r;

    // Directed vectors for the 16-deep registered instance.
    for (int i = 1; i <= 16; i++) add(1, 0, 0, 1, 32'(i), i, 0, 0, 32'h0, i == 16);
    add(1, 0, 0, 1, 32'hDEAD, 16, 1, 0, 32'h0, 1);  // rejected write at full
    add(0, 0, 1, 1, 32'h0,    16, 0, 0, 32'h0, 1);  // clear_errors
    add(1, 1, 0, 1, 32'hBEEF, 16, 0, 0, 32'h1, 1);  // read+write at full
    for (int k = 1; k <= 16; k++)
      add(0, 1, 0, 1, 32'h0, 16 - k, 0, 0, (k < 16) ? 32'(k + 1) : 32'hBEEF, 0);
    add(1, 1, 0, 1, 32'h55, 1, 0, 1, 32'hBEEF, 0);  // read+write on empty
    add(0, 1, 0, 1, 32'h0,  0, 0, 1, 32'h55, 0);
    add(0, 0, 1, 1, 32'h0,  0, 0, 0, 32'h55, 0);

    // Reset state
    cycle(0, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 0, 32'h0);
    chk("reset count A", 32'(cnt0), 32'h0);
    chk1("reset empty A", emp0, 1'b1);
    chk1("reset almost_empty A", ae0, 1'b1);
    chk1("reset full A", full0, 1'b0);
    chk1("reset almost_full A", af0, 1'b0);
    chk("reset data_out A", dout0, 32'h0);

    foreach (vecs[i]) begin
      cycle(vecs[i].w, vecs[i].r, vecs[i].c, vecs[i].rs, vecs[i].d);
      chk($sformatf("vec%0d count", i), 32'(cnt0), 32'(vecs[i].cnt));
      chk1($sformatf("vec%0d overflow", i), ov0, vecs[i].ov);
      chk1($sformatf("vec%0d underflow", i), un0, vecs[i].un);
      chk($sformatf("vec%0d data_out", i), dout0, vecs[i].dout);
      chk1($sformatf("vec%0d full", i), full0, vecs[i].full);
    end

    // 10-deep instance: 35 writes interleaved with reads, occupancy kept in 1..10 once filled.
    cycle(0, 0, 0, 0, 32'h0);
    writes = 0;
    iter   = 0;
    while (writes < 35 && iter < 400) begin
      n = qsize(1);
      w = (n < 10) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 1) == 1);
      r = (n >= 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
      if (n == 10 && w) r = 1'b1;
      if (n == 0) w = 1'b1;
      cycle(w, r, 0, 1, $urandom);
      chk1("B occupancy 1..10", (cnt1 >= 4'd1) && (cnt1 <= 4'd10), 1'b1);
      if (w) writes++;
      iter++;
    end
    chk("B writes issued", 32'(writes), 32'd35);

    // Show-ahead instance
    cycle(0, 0, 0, 0, 32'h0);
    cycle(1, 0, 0, 1, 32'hA);
    chk("fwft first word", dout2, 32'hA);
    chk1("fwft not empty", emp2, 1'b0);
    cycle(1, 0, 0, 1, 32'hB);
    chk("fwft head held", dout2, 32'hA);
    cycle(0, 1, 0, 1, 32'h0);
    chk("fwft after pop1", dout2, 32'hB);
    cycle(0, 1, 0, 1, 32'h0);
    chk("fwft after pop2", dout2, 32'h0);
    chk1("fwft empty", emp2, 1'b1);

    // Reset mid-operation with a write in the reset cycle
    cycle(0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 1, 32'h100 + 32'(i));
    cycle(0, 1, 0, 1, 32'h0);
    chk("pre-reset count A", 32'(cnt0), 32'd5);
    chk("pre-reset data_out A", dout0, 32'h100);
    cycle(1, 0, 0, 0, 32'h777);
    chk("mid-reset count A", 32'(cnt0), 32'h0);
    chk1("mid-reset empty A", emp0, 1'b1);
    chk1("mid-reset overflow A", ov0, 1'b0);
    chk1("mid-reset underflow A", un0, 1'b0);
    chk("mid-reset data_out A", dout0, 32'h0);
    cycle(1, 0, 0, 1, 32'h99);
    cycle(0, 1, 0, 1, 32'h0);
    chk("post-reset readback A", dout0, 32'h99);
    chk("post-reset count A", 32'(cnt0), 32'h0);

    // Random traffic with occasional clears and resets
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, $urandom_range(0, 39) != 0, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_counted.md
Name: fifo_counted

Overview:
- Parametrised synchronous single-clock FIFO; successor to the basic command/data FIFO.
- Adds full DEPTH-entry usage with arbitrary depth (power of two not required), an occupancy count and programmable almost-full/almost-empty flags.
- Adds a selectable show-ahead read mode and sticky overflow/underflow error flags.
- Sits between CPU-side producers and peripheral consumers (UART, video, bus bridges) in the CLOCK_50 domain.

Parameters:
- DATA_WIDTH, 32, width of each stored item.
- DEPTH, 16, number of storage entries; any integer >= 2.
- ALMOST_FULL_LEVEL, DEPTH-4, almost_full asserts when count >= this value.
- ALMOST_EMPTY_LEVEL, 4, almost_empty asserts when count <= this value.
- SHOW_AHEAD, 0, selects read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
- CLOCK_50  input  1  system clock; all logic is on the rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- data_in  input  DATA_WIDTH  write data.
- write  input  1  write request.
- read  input  1  read/pop request.
- clear_errors  input  1  clears overflow and underflow.
- data_out  output  DATA_WIDTH  read data.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- almost_empty  output  1  count <= ALMOST_EMPTY_LEVEL.
- almost_full  output  1  count >= ALMOST_FULL_LEVEL.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.

Behaviour:
- Reset (RST_N low at a clock edge) sets wr_ptr, rd_ptr, count, data_out, overflow and underflow to 0. Storage contents are not cleared.
- After reset: empty = 1, almost_empty = 1, full = 0, almost_full = 0, except almost_full = 1 if ALMOST_FULL_LEVEL == 0.
- A reset asserted mid-operation discards all contents on that edge. A write or read in that cycle is ignored.
- Pointers have width $clog2(DEPTH) and wrap from DEPTH-1 to 0 explicitly. They must never index past DEPTH-1.
- Read accept (rd_acc) = read && !empty.
- Write accept (wr_acc) = write && (!full || rd_acc). Writing while full is legal only when a read is accepted in the same cycle.
- Count update on each edge:
  - count + 1 if wr_acc && !rd_acc.
  - count - 1 if rd_acc && !wr_acc.
  - Otherwise unchanged.
- Simultaneous read and write on empty: the write is accepted and the read is rejected (underflow set). count goes 0 -> 1.
- Simultaneous read and write on full: both are accepted; count stays DEPTH.
- All flags are decoded from the count register, so they are registered-equivalent. A flag changes in the cycle after the accepting edge.
- SHOW_AHEAD = 0:
  - data_out is a register loaded with mem[rd_ptr] on the rd_acc edge, so it is valid one cycle after read.
  - data_out holds its value when there is no rd_acc.
- SHOW_AHEAD = 1:
  - data_out = mem[rd_ptr] combinationally while !empty, and 0 while empty.
  - read pops the shown item; the next item appears in the same cycle the pop edge completes.
  - A word written into an empty FIFO appears on data_out the cycle after its write edge.
- overflow sets on any edge where write && !wr_acc; underflow sets on any edge where read && !rd_acc.
- Rejected operations have no other effect: pointers, count and storage are unchanged.
- clear_errors clears both sticky flags. If a new error occurs in the same cycle, set wins.
- Whether DEPTH is a power of two must not change behaviour or occupancy. All DEPTH entries are usable.

Test Plan:
- DEPTH=16, SHOW_AHEAD=0: write 0x1..0x10 on consecutive cycles, then read 16 times.
  - full rises after the 16th write, with count=16.
  - data_out returns 0x1..0x10 in order, each one cycle after its read.
  - empty returns after the last read; overflow and underflow stay 0.
- Full boundary: at count=16, pulse write alone with 0xDEAD.
  - Write is rejected; overflow=1; contents unchanged.
  - clear_errors for one cycle -> overflow=0.
  - write+read together at full: count stays 16, the head item is read out, and 0xBEEF ends up at the tail.
- Empty boundary: at count=0, assert read+write with 0x55 together.
  - underflow=1 and count=1.
  - The next read returns 0x55.
- DEPTH=10, ALMOST_FULL_LEVEL=8, ALMOST_EMPTY_LEVEL=2: run 35 writes interleaved with reads, keeping occupancy between 1 and 10.
  - Pointers wrap correctly and data order matches the reference queue.
  - almost_full = (count >= 8) and almost_empty = (count <= 2) on every cycle.
- SHOW_AHEAD=1: write 0xA then 0xB.
  - data_out = 0xA the cycle after the first write edge, with no read issued.
  - After one read, data_out = 0xB; after a second read, data_out = 0 and empty = 1.
- Reset mid-operation: with count=5, assert RST_N=0 for one cycle together with write=1.
  - count=0, empty=1, overflow=0, underflow=0, data_out=0.
  - The write is ignored; the next write/read pair returns the newly written value.
